sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Pipelined N-channel sprite compositor for the VGA pixel path. Per pixel it tests NUM_SPRITES
//  bounding boxes, issues one sprite-RAM read per channel, drops transparent texels and
//  resolves z-priority over a background colour (map/text layer). Drives Red/Green/Blue.
//  Accumulates per-frame sprite-0 (Pac-Man) vs sprite-k overlap flags for game logic.
// PARAMETERS
//  NUM_SPRITES  4         sprite channels; index 0 = highest priority
//  COORD_W      10        width of DrawX/DrawY and sprite coordinates
//  SPRITE_W     26        sprite box width in pixels
//  SPRITE_H     26        sprite box height in pixels
//  ADDR_W       12        sprite RAM address width per channel
//  ROM_LAT      1         sprite RAM read latency in cycles (>=1)
//  TRANSP_KEY   24'h000000  texel value treated as transparent
//  CLIP_X       404       pixels with DrawX > CLIP_X are forced black
// PORTS
//  Clk           in   1                      pixel clock
//  Reset         in   1                      asynchronous, active-high reset
//  blank         in   1                      0 = blanking interval, 1 = active video
//  DrawX, DrawY  in   COORD_W                current pixel coordinate
//  bg_rgb        in   24                     background colour for (DrawX,DrawY), same cycle
//  spr_en        in   NUM_SPRITES            per-channel enable
//  spr_x, spr_y  in   NUM_SPRITES*COORD_W    top-left corner per channel (ch k at [k*COORD_W +: COORD_W])
//  spr_base      in   NUM_SPRITES*ADDR_W     RAM base address of current animation frame per channel
//  rom_addr      out  NUM_SPRITES*ADDR_W     registered read address per channel
//  rom_data      in   NUM_SPRITES*24         texel, valid ROM_LAT cycles after rom_addr
//  Red,Green,Blue out 8 each                 composited colour
//  hit_id        out  $clog2(NUM_SPRITES)+1  winning channel; all-ones = background
//  collide       out  NUM_SPRITES            frame collision flags; bit 0 always 0
// BEHAVIOUR
//  Reset: Red/Green/Blue=0, hit_id=all-ones, collide=0, rom_addr=0, all pipeline regs and
//   delayed blank cleared (output black until pipeline refills), overlap accumulator cleared.
//  Pipeline, fixed latency L = ROM_LAT+2 from DrawX/DrawY/bg_rgb/blank to RGB:
//   S1 (cycle 1): per channel dx=DrawX-x, dy=DrawY-y in COORD_W+1 signed bits;
//    in_box = spr_en & 0<=dx<SPRITE_W & 0<=dy<SPRITE_H;
//    rom_addr <= spr_base + dy*SPRITE_W + dx (mod 2^ADDR_W), or spr_base when !in_box.
//   S2 (ROM_LAT cycles): delay in_box, bg_rgb, blank, clip flag alongside RAM read.
//   S3: opaque_k = in_box_k & (rom_data_k != TRANSP_KEY); winner = lowest k with opaque_k;
//    RGB <= rom_data_winner, hit_id <= winner; no winner -> bg_rgb, hit_id all-ones.
//    Delayed blank==0 or clip flag -> RGB=0, hit_id all-ones (no collision counted).
//  Sprite coordinates near 0 or screen edge: negative dx/dy is a miss, no wrap-around.
//   Box partially off-screen draws only the visible part.
//  Collision: acc_k |= opaque_0 & opaque_k (k>=1) in S3 for unblanked, unclipped pixels.
//   Frame boundary = S3 pixel with delayed (DrawX,DrawY)==(0,0): collide <= acc (including
//   that pixel's contribution), acc cleared same cycle. collide holds one full frame.
//  Inputs spr_* may change at any cycle; each pixel uses values sampled at its S1 cycle.
//  Reset mid-frame: acc discarded; first frame after reset may publish partial flags.
// TESTING
//  1 Reset asserted mid-frame -> RGB=0, collide=0, hit_id=all-ones immediately (async).
//  2 Only ch1 enabled at (100,50), texel=24'hFF0000: pixel (100,50) -> rom_addr=base+0 at
//    cycle 1, RGB=FF/00/00 at cycle L; (125,75) -> base+675; (126,50),(99,50) -> bg_rgb.
//  3 ch0 and ch2 both at (10,10), ch0 texel TRANSP_KEY, ch2 texel 24'h00FF00 -> green,
//    hit_id=2; ch0 texel 24'hFFFF00 -> yellow, hit_id=0.
//  4 ch0 and ch3 opaque overlap at one pixel in frame N -> collide=4'b1000 from frame N+1
//    start for exactly one frame; no overlap in N+1 -> collide=0 at N+2 start.
//  5 blank=0 or DrawX=405 over opaque sprite -> RGB=0, no collision accumulated.
//  6 spr_x=0, spr_y=470 (box crosses bottom edge) -> rows 470..479 drawn, no wrap
//    to top rows; ROM_LAT=3 build -> latency exactly 5 cycles.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: pipelined N-channel sprite overlay for the VGA pixel path.
// Box test and RAM address, RAM read delay, then priority/transparency resolve.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          COORD_W     = 10,
    parameter int          SPRITE_W    = 26,
    parameter int          SPRITE_H    = 26,
    parameter int          ADDR_W      = 12,
    parameter int          ROM_LAT     = 1,
    parameter logic [23:0] TRANSP_KEY  = 24'h000000,
    parameter int          CLIP_X      = 404
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             blank,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic [23:0]                      bg_rgb,
    input  logic [NUM_SPRITES-1:0]           spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0]   spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0]   spr_y,
    input  logic [NUM_SPRITES*ADDR_W-1:0]    spr_base,
    output logic [NUM_SPRITES*ADDR_W-1:0]    rom_addr,
    input  logic [NUM_SPRITES*24-1:0]        rom_data,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic [$clog2(NUM_SPRITES):0]     hit_id,
    output logic [NUM_SPRITES-1:0]           collide
);

    localparam int DW  = COORD_W + 1;
    localparam int IDW = $clog2(NUM_SPRITES) + 1;

    logic signed [DW-1:0]          dx;
    logic signed [DW-1:0]          dy;
    logic [ADDR_W-1:0]             off;
    logic [NUM_SPRITES-1:0]        in_box_c;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_c;

    logic [NUM_SPRITES-1:0]        box_p [ROM_LAT+1];
    logic [23:0]                   bg_p  [ROM_LAT+1];
    logic [ROM_LAT:0]              blank_p;
    logic [ROM_LAT:0]              clip_p;
    logic [ROM_LAT:0]              org_p;

    logic [NUM_SPRITES-1:0]        opaque;
    logic [NUM_SPRITES-1:0]        hits;
    logic [NUM_SPRITES-1:0]        acc;
    logic [NUM_SPRITES-1:0]        acc_next;
    logic [23:0]                   win_rgb;
    logic [IDW-1:0]                win_id;
    logic                          live;

    // Box test per channel; negative offsets are misses, so boxes never wrap.
    always_comb begin
        in_box_c = '0;
        addr_c   = '0;
        dx       = '0;
        dy       = '0;
        off      = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            dx = $signed({1'b0, DrawX}) - $signed({1'b0, spr_x[k*COORD_W +: COORD_W]});
            dy = $signed({1'b0, DrawY}) - $signed({1'b0, spr_y[k*COORD_W +: COORD_W]});
            in_box_c[k] = spr_en[k]
                        && !dx[DW-1] && (dx[DW-2:0] < COORD_W'(SPRITE_W))
                        && !dy[DW-1] && (dy[DW-2:0] < COORD_W'(SPRITE_H));
            off = ADDR_W'(dy[DW-2:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(dx[DW-2:0]);
            addr_c[k*ADDR_W +: ADDR_W] = spr_base[k*ADDR_W +: ADDR_W]
                                       + (in_box_c[k] ? off : '0);
        end
    end

    // Issue RAM reads and carry per-pixel side data alongside the RAM latency.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            blank_p  <= '0;
            clip_p   <= '0;
            org_p    <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                box_p[i] <= '0;
                bg_p[i]  <= '0;
            end
        end else begin
            rom_addr   <= addr_c;
            box_p[0]   <= in_box_c;
            bg_p[0]    <= bg_rgb;
            blank_p[0] <= blank;
            clip_p[0]  <= (DrawX > COORD_W'(CLIP_X));
            org_p[0]   <= (DrawX == '0) && (DrawY == '0);
            for (int i = 1; i <= ROM_LAT; i++) begin
                box_p[i]   <= box_p[i-1];
                bg_p[i]    <= bg_p[i-1];
                blank_p[i] <= blank_p[i-1];
                clip_p[i]  <= clip_p[i-1];
                org_p[i]   <= org_p[i-1];
            end
        end
    end

    // Drop transparent texels, pick the lowest-index opaque channel, gather overlaps.
    always_comb begin
        opaque  = '0;
        win_rgb = bg_p[ROM_LAT];
        win_id  = '1;
        live    = blank_p[ROM_LAT] && !clip_p[ROM_LAT];
        for (int k = 0; k < NUM_SPRITES; k++) begin
            opaque[k] = box_p[ROM_LAT][k]
                      && (rom_data[k*24 +: 24] != TRANSP_KEY);
        end
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                win_rgb = rom_data[k*24 +: 24];
                win_id  = IDW'(k);
            end
        end
        hits = '0;
        if (live && opaque[0]) begin
            hits = opaque;
        end
        hits[0]  = 1'b0;
        acc_next = acc | hits;
    end

    // Register the composited pixel and publish overlap flags at each frame origin.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Red     <= '0;
            Green   <= '0;
            Blue    <= '0;
            hit_id  <= '1;
            collide <= '0;
            acc     <= '0;
        end else begin
            if (live) begin
                {Red, Green, Blue} <= win_rgb;
                hit_id             <= win_id;
            end else begin
                {Red, Green, Blue} <= 24'h000000;
                hit_id             <= '1;
            end
            if (org_p[ROM_LAT]) begin
                collide <= acc_next;
                acc     <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: scoreboard bench with a behavioural sprite RAM.
// Expected pixels/addresses are queued at drive time and compared on output.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int CW = 10;
    localparam int AW = 12;
    localparam int RL = 3;
    localparam int L  = RL + 2;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic           blank = 1'b0;
    logic [CW-1:0]  DrawX = '0;
    logic [CW-1:0]  DrawY = '0;
    logic [23:0]    bg_rgb = '0;
    logic [NS-1:0]  spr_en = '0;
    logic [NS*CW-1:0] spr_x;
    logic [NS*CW-1:0] spr_y;
    logic [NS*AW-1:0] spr_base;
    logic [NS*AW-1:0] rom_addr;
    logic [NS*24-1:0] rom_data;
    logic [7:0]     Red, Green, Blue;
    logic [2:0]     hit_id;
    logic [NS-1:0]  collide;

    logic [CW-1:0]  sx [NS];
    logic [CW-1:0]  sy [NS];
    logic [AW-1:0]  sb [NS];
    logic [23:0]    tex [NS][4096];
    logic [23:0]    rd [NS][RL];

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic [2:0]  hid;
        logic [3:0]  col;
    } exp_t;

    typedef struct {
        int          due;
        logic [47:0] addr;
    } aexp_t;

    exp_t  q[$];
    aexp_t aq[$];
    int    edge_cnt = 0;
    int    checks = 0;
    int    errors = 0;
    logic [3:0] acc_m = '0;
    logic [3:0] col_m = '0;

    sprite_compositor #(
        .NUM_SPRITES(NS), .COORD_W(CW), .SPRITE_W(26), .SPRITE_H(26),
        .ADDR_W(AW), .ROM_LAT(RL), .TRANSP_KEY(24'h000000), .CLIP_X(404)
    ) dut (
        .Clk(Clk), .Reset(Reset), .blank(blank),
        .DrawX(DrawX), .DrawY(DrawY), .bg_rgb(bg_rgb),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_base(spr_base), .rom_addr(rom_addr), .rom_data(rom_data),
        .Red(Red), .Green(Green), .Blue(Blue),
        .hit_id(hit_id), .collide(collide)
    );

    always #5 Clk = ~Clk;

    // Count active edges so outputs can be matched to the pixel that caused them.
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    // Sprite RAM with RL cycles of read latency.
    always @(posedge Clk) begin
        for (int k = 0; k < NS; k++) begin
            rd[k][0] <= tex[k][rom_addr[k*AW +: AW]];
            for (int i = 1; i < RL; i++) rd[k][i] <= rd[k][i-1];
        end
    end

    // Pack per-channel settings onto the DUT buses.
    always_comb begin
        for (int k = 0; k < NS; k++) begin
            spr_x[k*CW +: CW]    = sx[k];
            spr_y[k*CW +: CW]    = sy[k];
            spr_base[k*AW +: AW] = sb[k];
            rom_data[k*24 +: 24] = rd[k][RL-1];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drain_due();
        exp_t  e;
        aexp_t a;
        while (q.size() > 0 && q[0].due <= edge_cnt) begin
            e = q.pop_front();
            check("rgb", {40'h0, Red, Green, Blue}, {40'h0, e.rgb});
            check("hit_id", {61'h0, hit_id}, {61'h0, e.hid});
            check("collide", {60'h0, collide}, {60'h0, e.col});
        end
        while (aq.size() > 0 && aq[0].due <= edge_cnt) begin
            a = aq.pop_front();
            check("rom_addr", {16'h0, rom_addr}, {16'h0, a.addr});
        end
    endtask

    task automatic model_push(input int x, input int y,
                              input logic [23:0] bg, input logic blk);
        exp_t        e;
        aexp_t       a;
        logic [3:0]  opq;
        logic [3:0]  hits;
        int          dx, dy, ad;
        logic        inb, live;
        opq    = '0;
        a.addr = '0;
        for (int k = 0; k < NS; k++) begin
            dx  = x - int'(sx[k]);
            dy  = y - int'(sy[k]);
            inb = spr_en[k] && dx >= 0 && dx < 26 && dy >= 0 && dy < 26;
            ad  = inb ? (int'(sb[k]) + dy * 26 + dx) % 4096 : int'(sb[k]);
            a.addr[k*AW +: AW] = AW'(ad);
            opq[k] = inb && (tex[k][ad] != 24'h0);
        end
        live  = blk && (x <= 404);
        e.rgb = bg;
        e.hid = 3'd7;
        for (int k = NS - 1; k >= 0; k--) begin
            if (opq[k]) begin
                e.rgb = tex[k][int'(a.addr[k*AW +: AW])];
                e.hid = 3'(k);
            end
        end
        if (!live) begin
            e.rgb = 24'h0;
            e.hid = 3'd7;
        end
        hits = (live && opq[0]) ? (opq & 4'b1110) : 4'b0000;
        if (x == 0 && y == 0) begin
            col_m = acc_m | hits;
            acc_m = '0;
        end else begin
            acc_m = acc_m | hits;
        end
        e.col = col_m;
        e.due = edge_cnt + L;
        a.due = edge_cnt + 1;
        q.push_back(e);
        aq.push_back(a);
    endtask

    task automatic step(input int x, input int y,
                        input logic [23:0] bg, input logic blk);
        @(negedge Clk);
        drain_due();
        DrawX  = CW'(x);
        DrawY  = CW'(y);
        bg_rgb = bg;
        blank  = blk;
        model_push(x, y, bg, blk);
    endtask

    task automatic settle();
        for (int i = 0; i < 8; i++) step(600, 300, 24'h0A0B0C, 1'b0);
    endtask

    task automatic fill_default();
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 4096; a++)
                tex[k][a] = {8'(32 + k * 48), 12'(a), 4'hA};
    endtask

    initial begin
        for (int k = 0; k < NS; k++) begin
            sx[k] = '0;
            sy[k] = '0;
            sb[k] = AW'(k * 1024);
        end
        fill_default();
        tex[1][12'h400] = 24'hFF0000;

        #1 Reset = 1'b1;
        #1;
        check("rst_rgb", {40'h0, Red, Green, Blue}, 64'h0);
        check("rst_hit", {61'h0, hit_id}, 64'h7);
        check("rst_col", {60'h0, collide}, 64'h0);
        check("rst_addr", {16'h0, rom_addr}, 64'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Single sprite on channel 1, edges of its box.
        spr_en = 4'b0010;
        sx[1] = 10'd100;
        sy[1] = 10'd50;
        step(0, 0, 24'h123456, 1'b1);
        step(100, 50, 24'h123456, 1'b1);
        step(125, 75, 24'h111111, 1'b1);
        step(126, 50, 24'h222222, 1'b1);
        step(99, 50, 24'h333333, 1'b1);
        step(100, 49, 24'h444444, 1'b1);
        step(100, 76, 24'h555555, 1'b1);
        for (int i = 0; i < 20; i++)
            step($urandom_range(95, 130), $urandom_range(45, 80),
                 24'($urandom), 1'b1);

        // Priority and transparency between channels 0 and 2.
        settle();
        spr_en = 4'b0101;
        sx[0] = 10'd10; sy[0] = 10'd10;
        sx[2] = 10'd10; sy[2] = 10'd10;
        tex[0][80] = 24'h000000;
        tex[2][12'h800 + 80] = 24'h00FF00;
        step(12, 13, 24'h777777, 1'b1);
        settle();
        tex[0][80] = 24'hFFFF00;
        step(12, 13, 24'h777777, 1'b1);

        // All channels stacked across the clip column with sparse texels.
        settle();
        spr_en = 4'b1111;
        for (int k = 0; k < NS; k++) begin
            sx[k] = 10'd390;
            sy[k] = 10'd100;
            for (int a = 0; a < 676; a++)
                tex[k][(int'(sb[k]) + a) % 4096] = $urandom_range(0, 1) ?
                    24'h0 : 24'($urandom_range(1, 24'hFFFFFF));
        end
        for (int i = 0; i < 40; i++)
            step($urandom_range(385, 420), $urandom_range(95, 130),
                 24'($urandom), ($urandom_range(0, 7) != 0));

        // Frame-level overlap flags between channels 0 and 3.
        settle();
        fill_default();
        spr_en = 4'b1001;
        sx[0] = 10'd300; sy[0] = 10'd200;
        sx[3] = 10'd300; sy[3] = 10'd200;
        step(0, 0, 24'h010101, 1'b1);
        step(305, 205, 24'h010101, 1'b1);
        step(310, 210, 24'h010101, 1'b1);
        step(0, 0, 24'h020202, 1'b1);
        step(10, 300, 24'h020202, 1'b1);
        step(0, 0, 24'h030303, 1'b1);
        step(10, 300, 24'h030303, 1'b1);

        // Clipped and blanked pixels never draw or collide.
        sx[0] = 10'd390; sx[3] = 10'd390;
        step(405, 205, 24'h040404, 1'b1);
        step(395, 205, 24'h040404, 1'b0);
        step(0, 0, 24'h050505, 1'b1);
        step(404, 205, 24'h050505, 1'b1);
        step(0, 0, 24'h060606, 1'b1);
        step(404, 206, 24'h060606, 1'b1);
        step(403, 207, 24'h060606, 1'b1);

        // Asynchronous reset mid-frame.
        #2 Reset = 1'b1;
        #1;
        check("mid_rgb", {40'h0, Red, Green, Blue}, 64'h0);
        check("mid_hit", {61'h0, hit_id}, 64'h7);
        check("mid_col", {60'h0, collide}, 64'h0);
        q.delete();
        aq.delete();
        acc_m = '0;
        col_m = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Boxes crossing the bottom and right edges do not wrap.
        spr_en = 4'b0001;
        sx[0] = 10'd0; sy[0] = 10'd470;
        step(0, 470, 24'h0000AA, 1'b1);
        step(25, 479, 24'h0000AA, 1'b1);
        step(3, 475, 24'h0000AA, 1'b1);
        step(5, 5, 24'h0000BB, 1'b1);
        step(0, 10, 24'h0000BB, 1'b1);
        step(0, 469, 24'h0000BB, 1'b1);
        step(26, 470, 24'h0000BB, 1'b1);
        sx[0] = 10'd1020;
        step(2, 475, 24'h0000CC, 1'b1);
        step(1020, 479, 24'h0000CC, 1'b1);
        step(1023, 470, 24'h0000CC, 1'b1);

        for (int i = 0; i < 20 && (q.size() > 0 || aq.size() > 0); i++) begin
            @(negedge Clk);
            drain_due();
        end
        check("drain", 64'(q.size() + aq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
